ref_fetch_scheduler: RTL and testbench
======================================

Name: ref_fetch_scheduler

Overview:
- Shares one reference block fetch unit between NUM_REQ requesters, e.g. cache-miss handler and prefetcher.
- The fetch unit takes an x/y/poc address plus valid and returns an 8x8 luma block.
- Arbitration is round-robin. The scheduler clamps coordinates to the picture, holds the fetch address stable for a fixed fetch latency and captures the block.
- The captured block is returned to the granted requester through a valid/ready response port.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ID_WIDTH, 2, width of the requester index; must satisfy 2^ID_WIDTH >= NUM_REQ.
- BLOCK_HORI_SIZE, 8, luma block width in pixels.
- BLOCK_VERT_SIZE, 8, luma block height in pixels.
- IMG_WIDTH, 1920, picture width in pixels.
- IMG_HEIGHT, 1080, picture height in pixels.
- FETCH_LATENCY, 2, cycles from fetch_valid_out rise to data capture (0..15).
- BIT_DEPTH, from the shared format definitions header, bits per pixel.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid_in  in  NUM_REQ  per-requester request valid.
- req_ready_out  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_x_in  in  32*NUM_REQ  packed x addresses; requester k at [32k +: 32].
- req_y_in  in  32*NUM_REQ  packed y addresses.
- req_poc_in  in  32*NUM_REQ  packed picture POCs.
- fetch_x_out  out  32  x address to the fetch unit.
- fetch_y_out  out  32  y address to the fetch unit.
- fetch_poc_out  out  32  POC to the fetch unit.
- fetch_valid_out  out  1  fetch request to the fetch unit.
- fetch_lu_blk_in  in  BIT_DEPTH*BLOCK_HORI_SIZE*BLOCK_VERT_SIZE  block returned by the fetch unit.
- resp_valid_out  out  1  response valid.
- resp_ready_in  in  1  response consumer ready.
- resp_id_out  out  ID_WIDTH  index of the requester the response belongs to.
- resp_lu_blk_out  out  BIT_DEPTH*BLOCK_HORI_SIZE*BLOCK_VERT_SIZE  captured block.
- busy_out  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs clear to 0: req_ready_out, fetch_*, resp_*, busy_out.
  - Round-robin pointer rr_ptr is set to NUM_REQ-1, so requester 0 wins first.
  - Fetch counter clears to 0.
  - Reset mid-transaction discards the transaction; no response is produced.
- FSM states are IDLE, FETCH and RESP. Only one transaction is outstanding at a time.
- IDLE:
  - If req_valid_in is nonzero, the grant g is the first set bit searching from (rr_ptr+1) mod NUM_REQ upward, wrapping.
  - req_ready_out[g]=1 combinationally in this cycle only; the handshake completes this cycle.
  - On the clock edge:
    - rr_ptr<=g and resp_id_out<=g.
    - fetch_poc_out<=poc[g].
    - fetch_x_out<=min(x[g], IMG_WIDTH-BLOCK_HORI_SIZE), unsigned 32-bit compare.
    - fetch_y_out<=min(y[g], IMG_HEIGHT-BLOCK_VERT_SIZE), unsigned 32-bit compare.
    - cnt<=0; go to FETCH.
  - req_ready_out is 0 in every other state.
- FETCH:
  - fetch_valid_out=1, registered: high from the first FETCH cycle.
  - fetch_x_out, fetch_y_out and fetch_poc_out hold constant.
  - cnt increments each cycle.
  - When cnt==FETCH_LATENCY: resp_lu_blk_out<=fetch_lu_blk_in, fetch_valid_out<=0, resp_valid_out<=1, go to RESP.
  - FETCH lasts exactly FETCH_LATENCY+1 cycles.
- RESP:
  - resp_valid_out and resp_lu_blk_out hold until resp_valid_out&&resp_ready_in.
  - On that cycle: resp_valid_out<=0, go to IDLE.
  - A new grant is possible in the following cycle. No bypass from RESP to FETCH.
- Latency: handshake at cycle T → fetch_valid_out high during T+1..T+1+FETCH_LATENCY → resp_valid_out high from T+2+FETCH_LATENCY.
- Requester rules:
  - A requester must hold valid and its address stable until it sees ready.
  - Dropping valid before a grant is legal; it is simply not granted.
  - Multiple simultaneous valids are served one per transaction in round-robin order.
  - A requester whose valid is held continuously is served within NUM_REQ transactions.
- fetch_x_out, fetch_y_out and fetch_poc_out retain their last values outside FETCH.
- Clamping is applied only at the upper edge. Inputs are unsigned, so there is no lower clamp.

Test Plan:
- Single request: requester 0 sends x=64, y=32, poc=1, FETCH_LATENCY=2, with the fetch model driving a block pattern.
  - Required: ready at T, fetch_valid high T+1..T+3 with addresses 64/32/1, resp_valid at T+4, resp_id=0, block matches the model.
- Round-robin: requesters 0 and 1 both hold valid for 4 transactions, resp_ready_in=1.
  - Required: grant order 0,1,0,1; the gap between consecutive resp_valid assertions is exactly FETCH_LATENCY+3 cycles.
- Clamp: x=1916, y=1078.
  - Required: fetch_x_out=1912, fetch_y_out=1072.
  - x=1912 and y=1072 pass through unchanged.
- Backpressure: resp_ready_in held 0 for 10 cycles.
  - Required: resp_valid and the block are stable, req_ready_out stays 0 and busy_out stays 1.
  - Releasing ready returns the FSM to IDLE in the next cycle.
- Mid-flight reset: assert reset during FETCH.
  - Required: all outputs are 0 immediately, with no clock edge needed.
  - After release, a requester-1-only request is granted with resp_id=1.
- FETCH_LATENCY=0: single request.
  - Required: fetch_valid high for exactly 1 cycle and resp_valid at T+2.

Source files
------------

// File: rtl/ref_fetch_scheduler_if.sv
// ref_fetch_scheduler_if
//   Bundles the requester, fetch-unit and response signals of the reference
//   block fetch scheduler.
//   slave  : scheduler side (drives ready, fetch address and response).
//   master : environment side (requesters, fetch unit, response consumer).
//   Signals:
//     req_valid_in/req_ready_out      per-requester handshake
//     req_x_in/req_y_in/req_poc_in    packed 32-bit addresses, requester k at [32k +: 32]
//     fetch_x/y/poc_out, fetch_valid_out, fetch_lu_blk_in   fetch unit port
//     resp_valid_out/resp_ready_in, resp_id_out, resp_lu_blk_out   response port
//     busy_out                        scheduler not idle
interface ref_fetch_scheduler_if #(
    parameter int NUM_REQ  = 2,
    parameter int ID_WIDTH = 2,
    parameter int BLK_W    = 512
);
    logic [NUM_REQ-1:0]    req_valid_in;
    logic [NUM_REQ-1:0]    req_ready_out;
    logic [32*NUM_REQ-1:0] req_x_in;
    logic [32*NUM_REQ-1:0] req_y_in;
    logic [32*NUM_REQ-1:0] req_poc_in;
    logic [31:0]           fetch_x_out;
    logic [31:0]           fetch_y_out;
    logic [31:0]           fetch_poc_out;
    logic                  fetch_valid_out;
    logic [BLK_W-1:0]      fetch_lu_blk_in;
    logic                  resp_valid_out;
    logic                  resp_ready_in;
    logic [ID_WIDTH-1:0]   resp_id_out;
    logic [BLK_W-1:0]      resp_lu_blk_out;
    logic                  busy_out;

    modport slave (
        input  req_valid_in, req_x_in, req_y_in, req_poc_in,
        input  fetch_lu_blk_in, resp_ready_in,
        output req_ready_out, fetch_x_out, fetch_y_out, fetch_poc_out,
        output fetch_valid_out, resp_valid_out, resp_id_out, resp_lu_blk_out,
        output busy_out
    );

    modport master (
        output req_valid_in, req_x_in, req_y_in, req_poc_in,
        output fetch_lu_blk_in, resp_ready_in,
        input  req_ready_out, fetch_x_out, fetch_y_out, fetch_poc_out,
        input  fetch_valid_out, resp_valid_out, resp_id_out, resp_lu_blk_out,
        input  busy_out
    );
endinterface

// File: rtl/ref_fetch_scheduler.sv
// ref_fetch_scheduler
//   Shares one reference block fetch unit between NUM_REQ requesters with
//   round-robin arbitration. A granted address is clamped to the picture,
//   held on the fetch port for FETCH_LATENCY+1 cycles, the returned 8x8 luma
//   block is captured and handed back over a valid/ready response port.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    ref_fetch_scheduler_if.slave (requests, fetch unit, response, busy)
module ref_fetch_scheduler #(
    parameter int NUM_REQ         = 2,
    parameter int ID_WIDTH        = 2,
    parameter int BLOCK_HORI_SIZE = 8,
    parameter int BLOCK_VERT_SIZE = 8,
    parameter int IMG_WIDTH       = 1920,
    parameter int IMG_HEIGHT      = 1080,
    parameter int FETCH_LATENCY   = 2,
    parameter int BIT_DEPTH       = 8
) (
    input  logic clk,
    input  logic reset,
    ref_fetch_scheduler_if.slave bus
);
    localparam int          BLK_W  = BIT_DEPTH * BLOCK_HORI_SIZE * BLOCK_VERT_SIZE;
    localparam int          VEXT_W = 1 << ID_WIDTH;
    localparam logic [31:0] X_MAX  = 32'(IMG_WIDTH - BLOCK_HORI_SIZE);
    localparam logic [31:0] Y_MAX  = 32'(IMG_HEIGHT - BLOCK_VERT_SIZE);
    localparam logic [3:0]  LAT    = 4'(FETCH_LATENCY);

    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

    state_t              state;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [3:0]          cnt;
    logic [31:0]         fetch_x_q;
    logic [31:0]         fetch_y_q;
    logic [31:0]         fetch_poc_q;
    logic                fetch_valid_q;
    logic                resp_valid_q;
    logic [ID_WIDTH-1:0] resp_id_q;
    logic [BLK_W-1:0]    resp_blk_q;
    logic                busy_q;

    logic [VEXT_W-1:0]   valid_ext;
    logic [ID_WIDTH:0]   cand_sum;
    logic                grant_found;
    logic [ID_WIDTH-1:0] grant_idx;
    logic [31:0]         sel_x;
    logic [31:0]         sel_y;
    logic [31:0]         sel_poc;
    logic [NUM_REQ-1:0]  ready_vec;

    // Upper-edge clamp only; coordinates are unsigned so no lower clamp.
    function automatic logic [31:0] clamp_coord(input logic [31:0] coord,
                                                input logic [31:0] lim);
        return (coord > lim) ? lim : coord;
    endfunction

    // Round-robin search starting one past the last grant, wrapping at NUM_REQ.
    // The valid vector is widened to 2^ID_WIDTH so the index width matches.
    always_comb begin
        valid_ext   = VEXT_W'(bus.req_valid_in);
        cand_sum    = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_sum = {1'b0, rr_ptr} + (ID_WIDTH+1)'(i);
            if (cand_sum >= (ID_WIDTH+1)'(NUM_REQ))
                cand_sum = cand_sum - (ID_WIDTH+1)'(NUM_REQ);
            if (!grant_found && valid_ext[cand_sum[ID_WIDTH-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_sum[ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_poc = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == ID_WIDTH'(k)) begin
                sel_x   = bus.req_x_in[32*k +: 32];
                sel_y   = bus.req_y_in[32*k +: 32];
                sel_poc = bus.req_poc_in[32*k +: 32];
            end
        end
    end

    // Ready is combinational; gating with reset keeps it low while reset is held.
    always_comb begin
        ready_vec = '0;
        for (int k = 0; k < NUM_REQ; k++)
            ready_vec[k] = reset && (state == IDLE) && grant_found &&
                           (grant_idx == ID_WIDTH'(k));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            rr_ptr        <= ID_WIDTH'(NUM_REQ - 1);
            cnt           <= '0;
            fetch_x_q     <= '0;
            fetch_y_q     <= '0;
            fetch_poc_q   <= '0;
            fetch_valid_q <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_blk_q    <= '0;
            busy_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        rr_ptr        <= grant_idx;
                        resp_id_q     <= grant_idx;
                        fetch_poc_q   <= sel_poc;
                        fetch_x_q     <= clamp_coord(sel_x, X_MAX);
                        fetch_y_q     <= clamp_coord(sel_y, Y_MAX);
                        cnt           <= '0;
                        fetch_valid_q <= 1'b1;
                        busy_q        <= 1'b1;
                        state         <= FETCH;
                    end
                end
                // p0 -> p1: address held on the fetch port until capture
                FETCH: begin
                    if (cnt == LAT) begin
                        resp_blk_q    <= bus.fetch_lu_blk_in;
                        fetch_valid_q <= 1'b0;
                        resp_valid_q  <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                // p1 -> p2: captured block held until the consumer accepts it
                RESP: begin
                    if (bus.resp_ready_in) begin
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_out   = ready_vec;
    assign bus.fetch_x_out     = fetch_x_q;
    assign bus.fetch_y_out     = fetch_y_q;
    assign bus.fetch_poc_out   = fetch_poc_q;
    assign bus.fetch_valid_out = fetch_valid_q;
    assign bus.resp_valid_out  = resp_valid_q;
    assign bus.resp_id_out     = resp_id_q;
    assign bus.resp_lu_blk_out = resp_blk_q;
    assign bus.busy_out        = busy_q;
endmodule

// File: tb/tb_ref_fetch_scheduler.sv
// tb_ref_fetch_scheduler
//   Scoreboard bench for ref_fetch_scheduler: one instance with
//   FETCH_LATENCY=2 (bus a) and one with FETCH_LATENCY=0 (bus b). The fetch
//   unit model returns the address-derived pattern only in the cycle its
//   latency says the block is ready, and its inverse otherwise.
module tb_ref_fetch_scheduler;
    localparam int BLK_W = 512;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] poc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   fcnt_a = 0;
    int   fcnt_b = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t ea;
    exp_t eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ref_fetch_scheduler_if #(.NUM_REQ(2), .ID_WIDTH(2), .BLK_W(BLK_W)) ifa ();
    ref_fetch_scheduler_if #(.NUM_REQ(2), .ID_WIDTH(2), .BLK_W(BLK_W)) ifb ();

    ref_fetch_scheduler #(.FETCH_LATENCY(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    ref_fetch_scheduler #(.FETCH_LATENCY(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    function automatic logic [BLK_W-1:0] pat(input logic [31:0] x, input logic [31:0] y,
                                             input logic [31:0] p);
        logic [BLK_W-1:0] r;
        for (int i = 0; i < 16; i++)
            r[32*i +: 32] = (x * 32'd40503) ^ (y << 12) ^ (p << 24) ^ (32'h01010101 * 32'(i));
        return r;
    endfunction

    function automatic exp_t mk(input logic [1:0] id, input logic [31:0] x,
                                input logic [31:0] y, input logic [31:0] p);
        exp_t e;
        e.id = id; e.x = x; e.y = y; e.poc = p;
        return e;
    endfunction

    // Fetch unit models: cycle count since fetch_valid rose.
    always @(posedge clk) begin
        fcnt_a <= ifa.fetch_valid_out ? fcnt_a + 1 : 0;
        fcnt_b <= ifb.fetch_valid_out ? fcnt_b + 1 : 0;
    end
    assign ifa.fetch_lu_blk_in = (ifa.fetch_valid_out && fcnt_a == 2) ?
        pat(ifa.fetch_x_out, ifa.fetch_y_out, ifa.fetch_poc_out) :
        ~pat(ifa.fetch_x_out, ifa.fetch_y_out, ifa.fetch_poc_out);
    assign ifb.fetch_lu_blk_in = (ifb.fetch_valid_out && fcnt_b == 0) ?
        pat(ifb.fetch_x_out, ifb.fetch_y_out, ifb.fetch_poc_out) :
        ~pat(ifb.fetch_x_out, ifb.fetch_y_out, ifb.fetch_poc_out);

    // Scoreboard: every accepted response is popped and compared.
    always @(negedge clk) begin
        if (reset === 1'b1 && ifa.resp_valid_out === 1'b1 && ifa.resp_ready_in === 1'b1) begin
            checks++;
            if (sb_a.size() == 0) begin
                failures++;
                $display("FAIL resp_a_unexpected id=%0d (no response expected)", ifa.resp_id_out);
            end else begin
                ea = sb_a.pop_front();
                if (ifa.resp_id_out !== ea.id ||
                    ifa.resp_lu_blk_out !== pat(ea.x, ea.y, ea.poc)) begin
                    failures++;
                    $display("FAIL resp_a id=%0d blk=%h expected id=%0d blk=%h",
                             ifa.resp_id_out, ifa.resp_lu_blk_out, ea.id, pat(ea.x, ea.y, ea.poc));
                end
            end
        end
        if (reset === 1'b1 && ifb.resp_valid_out === 1'b1 && ifb.resp_ready_in === 1'b1) begin
            checks++;
            if (sb_b.size() == 0) begin
                failures++;
                $display("FAIL resp_b_unexpected id=%0d (no response expected)", ifb.resp_id_out);
            end else begin
                eb = sb_b.pop_front();
                if (ifb.resp_id_out !== eb.id ||
                    ifb.resp_lu_blk_out !== pat(eb.x, eb.y, eb.poc)) begin
                    failures++;
                    $display("FAIL resp_b id=%0d blk=%h expected id=%0d blk=%h",
                             ifb.resp_id_out, ifb.resp_lu_blk_out, eb.id, pat(eb.x, eb.y, eb.poc));
                end
            end
        end
    end

    task automatic set_addr_a(input int k, input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] p);
        ifa.req_x_in[32*k +: 32]   = x;
        ifa.req_y_in[32*k +: 32]   = y;
        ifa.req_poc_in[32*k +: 32] = p;
    endtask

    task automatic test_reset;
        ifa.req_valid_in = 2'b01;
        ifb.req_valid_in = 2'b01;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (ifa.req_ready_out !== 2'b00 || ifb.req_ready_out !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready got a=%b b=%b want 00", ifa.req_ready_out, ifb.req_ready_out);
        end
        checks++;
        if ({ifa.fetch_valid_out, ifa.fetch_x_out, ifa.fetch_y_out, ifa.fetch_poc_out} !== 97'd0) begin
            failures++;
            $display("FAIL reset_fetch got v=%b x=%0d y=%0d poc=%0d want 0", ifa.fetch_valid_out,
                     ifa.fetch_x_out, ifa.fetch_y_out, ifa.fetch_poc_out);
        end
        checks++;
        if (ifa.resp_valid_out !== 1'b0 || ifa.resp_id_out !== 2'd0 || ifa.resp_lu_blk_out !== '0) begin
            failures++;
            $display("FAIL reset_resp got v=%b id=%0d want 0", ifa.resp_valid_out, ifa.resp_id_out);
        end
        checks++;
        if (ifa.busy_out !== 1'b0 || ifb.busy_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got a=%b b=%b want 0", ifa.busy_out, ifb.busy_out);
        end
        ifa.req_valid_in = 2'b00;
        ifb.req_valid_in = 2'b00;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ifa.busy_out !== 1'b0 || ifa.fetch_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%b fv=%b want 0", ifa.busy_out, ifa.fetch_valid_out);
        end
    endtask

    task automatic test_single;
        logic exp_fv, exp_rv;
        @(posedge clk); #1;
        sb_a.push_back(mk(2'd0, 32'd64, 32'd32, 32'd1));
        set_addr_a(0, 32'd64, 32'd32, 32'd1);
        ifa.req_valid_in  = 2'b01;
        ifa.resp_ready_in = 1'b1;
        @(negedge clk);
        checks++;
        if (ifa.req_ready_out !== 2'b01) begin
            failures++;
            $display("FAIL single_ready got %b want 01", ifa.req_ready_out);
        end
        @(posedge clk); #1 ifa.req_valid_in = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            exp_fv = (k <= 3);
            exp_rv = (k == 4);
            checks++;
            if (ifa.fetch_valid_out !== exp_fv || ifa.resp_valid_out !== exp_rv) begin
                failures++;
                $display("FAIL single_timing T+%0d got fv=%b rv=%b want fv=%b rv=%b", k,
                         ifa.fetch_valid_out, ifa.resp_valid_out, exp_fv, exp_rv);
            end
            if (exp_fv) begin
                checks++;
                if (ifa.fetch_x_out !== 32'd64 || ifa.fetch_y_out !== 32'd32 || ifa.fetch_poc_out !== 32'd1) begin
                    failures++;
                    $display("FAIL single_addr T+%0d got %0d/%0d/%0d want 64/32/1", k,
                             ifa.fetch_x_out, ifa.fetch_y_out, ifa.fetch_poc_out);
                end
            end
            checks++;
            if (ifa.busy_out !== (k <= 4)) begin
                failures++;
                $display("FAIL single_busy T+%0d got %b want %b", k, ifa.busy_out, (k <= 4));
            end
        end
    endtask

    task automatic test_backpressure;
        logic got;
        @(posedge clk); #1;
        sb_a.push_back(mk(2'd0, 32'd8, 32'd16, 32'd3));
        set_addr_a(0, 32'd8, 32'd16, 32'd3);
        ifa.req_valid_in  = 2'b01;
        ifa.resp_ready_in = 1'b0;
        @(negedge clk);
        checks++;
        if (ifa.req_ready_out !== 2'b01) begin
            failures++;
            $display("FAIL bp_ready got %b want 01", ifa.req_ready_out);
        end
        @(posedge clk); #1 ifa.req_valid_in = 2'b11;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (ifa.resp_valid_out === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL bp_resp_timeout got rv=%b want 1", ifa.resp_valid_out);
        end
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            checks++;
            if (ifa.resp_valid_out !== 1'b1 || ifa.resp_lu_blk_out !== pat(32'd8, 32'd16, 32'd3)) begin
                failures++;
                $display("FAIL bp_hold cycle %0d got rv=%b blk=%h", j, ifa.resp_valid_out, ifa.resp_lu_blk_out);
            end
            checks++;
            if (ifa.req_ready_out !== 2'b00 || ifa.busy_out !== 1'b1) begin
                failures++;
                $display("FAIL bp_stall cycle %0d got ready=%b busy=%b want 00/1", j,
                         ifa.req_ready_out, ifa.busy_out);
            end
        end
        @(posedge clk); #1;
        ifa.resp_ready_in = 1'b1;
        ifa.req_valid_in  = 2'b00;
        @(negedge clk);
        checks++;
        if (ifa.resp_valid_out !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_rv got %b want 1", ifa.resp_valid_out);
        end
        @(negedge clk);
        checks++;
        if (ifa.resp_valid_out !== 1'b0 || ifa.busy_out !== 1'b0) begin
            failures++;
            $display("FAIL bp_idle got rv=%b busy=%b want 0/0", ifa.resp_valid_out, ifa.busy_out);
        end
    endtask

    task automatic test_clamp;
        logic [31:0] xs[3]  = '{32'd1916, 32'd1912, 32'hFFFF_FFFF};
        logic [31:0] ys[3]  = '{32'd1078, 32'd1072, 32'h8000_0000};
        logic [31:0] exs[3] = '{32'd1912, 32'd1912, 32'd1912};
        logic [31:0] eys[3] = '{32'd1072, 32'd1072, 32'd1072};
        logic got;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            sb_a.push_back(mk(2'd1, exs[i], eys[i], 32'(10 + i)));
            set_addr_a(1, xs[i], ys[i], 32'(10 + i));
            ifa.req_valid_in  = 2'b10;
            ifa.resp_ready_in = 1'b1;
            got = 1'b0;
            for (int n = 0; n < 20 && !got; n++) begin
                @(negedge clk);
                if (ifa.req_ready_out !== 2'b00) got = 1'b1;
            end
            checks++;
            if (!got || ifa.req_ready_out !== 2'b10) begin
                failures++;
                $display("FAIL clamp_ready[%0d] got %b want 10", i, ifa.req_ready_out);
            end
            @(posedge clk); #1 ifa.req_valid_in = 2'b00;
            @(negedge clk);
            checks++;
            if (ifa.fetch_x_out !== exs[i] || ifa.fetch_y_out !== eys[i] || ifa.fetch_valid_out !== 1'b1) begin
                failures++;
                $display("FAIL clamp_addr[%0d] got x=%0d y=%0d fv=%b want x=%0d y=%0d fv=1", i,
                         ifa.fetch_x_out, ifa.fetch_y_out, ifa.fetch_valid_out, exs[i], eys[i]);
            end
            got = 1'b0;
            for (int n = 0; n < 20 && !got; n++) begin
                @(negedge clk);
                if (ifa.busy_out === 1'b0) got = 1'b1;
            end
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL clamp_done[%0d] got busy=%b want 0", i, ifa.busy_out);
            end
        end
    endtask

    task automatic test_round_robin;
        int grants = 0;
        int nrise = 0;
        int last_rise = 0;
        logic prev_rv = 1'b0;
        logic [1:0] want;
        @(posedge clk); #1;
        sb_a.push_back(mk(2'd0, 32'd100, 32'd200, 32'd5));
        sb_a.push_back(mk(2'd1, 32'd300, 32'd400, 32'd6));
        sb_a.push_back(mk(2'd0, 32'd100, 32'd200, 32'd5));
        sb_a.push_back(mk(2'd1, 32'd300, 32'd400, 32'd6));
        set_addr_a(0, 32'd100, 32'd200, 32'd5);
        set_addr_a(1, 32'd300, 32'd400, 32'd6);
        ifa.req_valid_in  = 2'b11;
        ifa.resp_ready_in = 1'b1;
        for (int n = 0; n < 80 && !(grants == 4 && nrise == 4 && ifa.busy_out === 1'b0); n++) begin
            @(negedge clk);
            if (ifa.resp_valid_out === 1'b1 && !prev_rv) begin
                if (nrise > 0) begin
                    checks++;
                    if (cyc - last_rise != 5) begin
                        failures++;
                        $display("FAIL rr_gap got %0d cycles want 5", cyc - last_rise);
                    end
                end
                last_rise = cyc;
                nrise++;
            end
            prev_rv = (ifa.resp_valid_out === 1'b1);
            if (ifa.req_ready_out !== 2'b00) begin
                want = (grants % 2 == 0) ? 2'b01 : 2'b10;
                checks++;
                if (ifa.req_ready_out !== want) begin
                    failures++;
                    $display("FAIL rr_order grant %0d got %b want %b", grants, ifa.req_ready_out, want);
                end
                grants++;
                if (grants == 4) begin
                    @(posedge clk); #1 ifa.req_valid_in = 2'b00;
                end
            end
        end
        checks++;
        if (grants != 4 || nrise != 4) begin
            failures++;
            $display("FAIL rr_count got grants=%0d resps=%0d want 4/4", grants, nrise);
        end
    endtask

    task automatic test_midflight_reset;
        logic got;
        @(posedge clk); #1;
        sb_a.push_back(mk(2'd0, 32'd500, 32'd600, 32'd7));
        set_addr_a(0, 32'd500, 32'd600, 32'd7);
        ifa.req_valid_in  = 2'b01;
        ifa.resp_ready_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ifa.fetch_valid_out !== 1'b1) begin
            failures++;
            $display("FAIL mid_in_fetch got fv=%b want 1", ifa.fetch_valid_out);
        end
        #1 reset = 1'b0;
        void'(sb_a.pop_back());
        #1;
        checks++;
        if (ifa.req_ready_out !== 2'b00 || ifa.busy_out !== 1'b0 || ifa.fetch_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL mid_ctrl got ready=%b busy=%b fv=%b want 0", ifa.req_ready_out,
                     ifa.busy_out, ifa.fetch_valid_out);
        end
        checks++;
        if ({ifa.fetch_x_out, ifa.fetch_y_out, ifa.fetch_poc_out} !== 96'd0 ||
            ifa.resp_valid_out !== 1'b0 || ifa.resp_id_out !== 2'd0 || ifa.resp_lu_blk_out !== '0) begin
            failures++;
            $display("FAIL mid_data got x=%0d y=%0d poc=%0d rv=%b id=%0d want 0", ifa.fetch_x_out,
                     ifa.fetch_y_out, ifa.fetch_poc_out, ifa.resp_valid_out, ifa.resp_id_out);
        end
        ifa.req_valid_in = 2'b00;
        @(posedge clk); #1 reset = 1'b1;
        sb_a.push_back(mk(2'd1, 32'd700, 32'd800, 32'd8));
        set_addr_a(1, 32'd700, 32'd800, 32'd8);
        ifa.req_valid_in = 2'b10;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (ifa.req_ready_out !== 2'b00) got = 1'b1;
        end
        checks++;
        if (!got || ifa.req_ready_out !== 2'b10) begin
            failures++;
            $display("FAIL mid_regrant got %b want 10", ifa.req_ready_out);
        end
        @(posedge clk); #1 ifa.req_valid_in = 2'b00;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (ifa.busy_out === 1'b0) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL mid_done got busy=%b want 0", ifa.busy_out);
        end
    endtask

    task automatic test_latency_zero;
        logic exp_fv, exp_rv;
        @(posedge clk); #1;
        sb_b.push_back(mk(2'd0, 32'd40, 32'd24, 32'd9));
        ifb.req_x_in[31:0]   = 32'd40;
        ifb.req_y_in[31:0]   = 32'd24;
        ifb.req_poc_in[31:0] = 32'd9;
        ifb.req_valid_in     = 2'b01;
        ifb.resp_ready_in    = 1'b1;
        @(negedge clk);
        checks++;
        if (ifb.req_ready_out !== 2'b01) begin
            failures++;
            $display("FAIL lat0_ready got %b want 01", ifb.req_ready_out);
        end
        @(posedge clk); #1 ifb.req_valid_in = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp_fv = (k == 1);
            exp_rv = (k == 2);
            checks++;
            if (ifb.fetch_valid_out !== exp_fv || ifb.resp_valid_out !== exp_rv) begin
                failures++;
                $display("FAIL lat0_timing T+%0d got fv=%b rv=%b want fv=%b rv=%b", k,
                         ifb.fetch_valid_out, ifb.resp_valid_out, exp_fv, exp_rv);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.req_valid_in  = '0;
        ifa.req_x_in      = '0;
        ifa.req_y_in      = '0;
        ifa.req_poc_in    = '0;
        ifa.resp_ready_in = 1'b1;
        ifb.req_valid_in  = '0;
        ifb.req_x_in      = '0;
        ifb.req_y_in      = '0;
        ifb.req_poc_in    = '0;
        ifb.resp_ready_in = 1'b1;
        test_reset();
        test_single();
        test_backpressure();
        test_clamp();
        test_round_robin();
        test_midflight_reset();
        test_latency_zero();
        repeat (3) @(negedge clk);
        checks++;
        if (sb_a.size() != 0 || sb_b.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got a=%0d b=%0d pending want 0", sb_a.size(), sb_b.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
